// File: rtl/bbox_pkg.sv
// Shared definitions for the LiDAR bounding-box path.
// Holds the default box word width, the empty-slot value, the field layout
// of a packed box (four 16-bit coordinates) for downstream consumers, and a
// small saturating-increment helper used by the frame table.
package bbox_pkg;

  localparam int          BBOX_W_DEF    = 64;
  localparam logic [63:0] CLEAR_VAL_DEF = 64'h1;

  // Field layout inside one packed box word (LSB offsets, 16 bits each).
  localparam int FIELD_W   = 16;
  localparam int X_MIN_LSB = 0;
  localparam int X_MAX_LSB = 16;
  localparam int Y_MIN_LSB = 32;
  localparam int Y_MAX_LSB = 48;

  typedef struct packed {
    logic [15:0] y_max;
    logic [15:0] y_min;
    logic [15:0] x_max;
    logic [15:0] x_min;
  } bbox_t;

  // Increment that sticks at 255 instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/bbox_decimator.sv
// Keeps one of every DECIM valid boxes.
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   clear_i      synchronous restart of the count (frame boundary)
//   box_valid_i  a box is offered this cycle
//   store_en_o   this box is the DECIM-th one and must be stored
// store_en_o is combinational from the current count so a box arriving
// together with clear_i is still judged against the ending frame's count.
module bbox_decimator #(
  parameter int DECIM = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic box_valid_i,
  output logic store_en_o
);

  localparam int            CW   = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [CW-1:0] LAST = CW'(DECIM - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign store_en_o = box_valid_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (box_valid_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/bbox_frame_table.sv
// Double-buffered bounding-box table.
// Decimated boxes fill a write bank; frame_end atomically copies it to the
// published bank (bbox_out/slot_valid/box_count/drop_count/overflow) and
// restarts the write bank empty.
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   frame_end    one-cycle pulse closing the current frame
//   box_valid    qualifies box_data; there is no ready, every valid beat is
//                accepted in the cycle it is presented
//   box_data     packed box
//   bbox_out     published bank, slot i at [i*BOX_W +: BOX_W]
//   slot_valid   per-slot occupancy of the published frame
//   box_count    boxes in the published frame
//   drop_count   boxes discarded on a full table (WRAP=0), saturating
//   overflow     published frame reached full and dropped/overwrote
//   out_update   pulses the cycle the published outputs change
module bbox_frame_table
  import bbox_pkg::*;
#(
  parameter int               BOX_W     = BBOX_W_DEF,
  parameter int               DEPTH     = 10,
  parameter int               DECIM     = 3,
  parameter bit               WRAP      = 1'b0,
  parameter logic [BOX_W-1:0] CLEAR_VAL = BOX_W'(CLEAR_VAL_DEF)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       frame_end,
  input  logic                       box_valid,
  input  logic [BOX_W-1:0]           box_data,
  output logic [DEPTH*BOX_W-1:0]     bbox_out,
  output logic [DEPTH-1:0]           slot_valid,
  output logic [$clog2(DEPTH+1)-1:0] box_count,
  output logic [7:0]                 drop_count,
  output logic                       overflow,
  output logic                       out_update
);

  localparam int PW    = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             store_en;
  logic             full;

  logic [BOX_W-1:0] wr_bank_q [DEPTH];
  logic [BOX_W-1:0] wr_bank_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] fill_q, fill_d;
  logic [7:0]       wr_drop_q, wr_drop_d;
  logic             wr_ovf_q, wr_ovf_d;

  logic [BOX_W-1:0] pub_bank_q [DEPTH];
  logic [BOX_W-1:0] pub_bank_d [DEPTH];
  logic [DEPTH-1:0] pub_valid_q, pub_valid_d;
  logic [CNT_W-1:0] pub_count_q, pub_count_d;
  logic [7:0]       pub_drop_q, pub_drop_d;
  logic             pub_ovf_q, pub_ovf_d;
  logic             upd_q;

  bbox_decimator #(.DECIM(DECIM)) u_decim (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear_i     (frame_end),
    .box_valid_i (box_valid),
    .store_en_o  (store_en)
  );

  assign full = (fill_q == CNT_W'(DEPTH));

  always_comb begin
    wr_bank_d   = wr_bank_q;
    wr_ptr_d    = wr_ptr_q;
    fill_d      = fill_q;
    wr_drop_d   = wr_drop_q;
    wr_ovf_d    = wr_ovf_q;
    pub_bank_d  = pub_bank_q;
    pub_valid_d = pub_valid_q;
    pub_count_d = pub_count_q;
    pub_drop_d  = pub_drop_q;
    pub_ovf_d   = pub_ovf_q;

    // Store first, so a box coinciding with frame_end lands in the ending frame.
    if (store_en) begin
      if (!full || WRAP) begin
        wr_bank_d[wr_ptr_q] = box_data;
        wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        if (!full) fill_d   = fill_q + 1'b1;
        else       wr_ovf_d = 1'b1;
      end else begin
        wr_drop_d = sat_inc8(wr_drop_q);
        wr_ovf_d  = 1'b1;
      end
    end

    if (frame_end) begin
      pub_bank_d  = wr_bank_d;
      pub_count_d = fill_d;
      pub_drop_d  = wr_drop_d;
      pub_ovf_d   = wr_ovf_d;
      // Slots fill from 0 upward, so occupancy is a thermometer of fill.
      for (int i = 0; i < DEPTH; i++) begin
        pub_valid_d[i] = (CNT_W'(i) < fill_d);
      end
      for (int i = 0; i < DEPTH; i++) begin
        wr_bank_d[i] = CLEAR_VAL;
      end
      wr_ptr_d  = '0;
      fill_d    = '0;
      wr_drop_d = '0;
      wr_ovf_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        wr_bank_q[i]  <= CLEAR_VAL;
        pub_bank_q[i] <= CLEAR_VAL;
      end
      wr_ptr_q    <= '0;
      fill_q      <= '0;
      wr_drop_q   <= '0;
      wr_ovf_q    <= 1'b0;
      pub_valid_q <= '0;
      pub_count_q <= '0;
      pub_drop_q  <= '0;
      pub_ovf_q   <= 1'b0;
      upd_q       <= 1'b0;
    end else begin
      wr_bank_q   <= wr_bank_d;
      wr_ptr_q    <= wr_ptr_d;
      fill_q      <= fill_d;
      wr_drop_q   <= wr_drop_d;
      wr_ovf_q    <= wr_ovf_d;
      pub_bank_q  <= pub_bank_d;
      pub_valid_q <= pub_valid_d;
      pub_count_q <= pub_count_d;
      pub_drop_q  <= pub_drop_d;
      pub_ovf_q   <= pub_ovf_d;
      upd_q       <= frame_end;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_flat
    assign bbox_out[g*BOX_W +: BOX_W] = pub_bank_q[g];
  end

  assign slot_valid = pub_valid_q;
  assign box_count  = pub_count_q;
  assign drop_count = pub_drop_q;
  assign overflow   = pub_ovf_q;
  assign out_update = upd_q;

endmodule

// File: doc/bbox_frame_table.md
# bbox_frame_table

Parametrised, double-buffered bounding-box table for the LiDAR detection path. Accepts a stream of packed boxes from the clustering stage and decimates it, keeping one of every DECIM valid boxes. Stored boxes fill a write bank; on each frame boundary the write bank is published atomically to a read bank that drives the overlay/AXI readout. Downstream therefore always sees one complete, stable frame, with a per-slot valid mask, a box count and overflow status.

## Interface
- BOX_W, 64: width of one packed bbox word
- DEPTH, 10: slots per bank (≥2)
- DECIM, 3: store one of every DECIM accepted boxes (1 = store all)
- WRAP, 0: full behaviour. 0 = drop further boxes; 1 = overwrite as a ring from slot 0
- CLEAR_VAL, 64'h1: value of an empty slot
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- frame_end  in  1  one-cycle pulse closing the current frame
- box_valid  in  1  box_data valid this cycle
- box_data  in  BOX_W  packed bbox
- bbox_out  out  DEPTH*BOX_W  published bank; slot i at bits [i*BOX_W +: BOX_W]
- slot_valid  out  DEPTH  bit i = slot i holds a box of the published frame
- box_count  out  $clog2(DEPTH+1)  boxes in published frame (saturates at DEPTH)
- drop_count  out  8  boxes lost to full table in published frame, saturating at 255
- overflow  out  1  published frame hit full (dropped or overwrote)
- out_update  out  1  one-cycle pulse: published outputs changed this cycle

## Operation
- Reset: both banks = CLEAR_VAL; slot_valid=0, box_count=0, drop_count=0, overflow=0, out_update=0; write pointer, fill count and decimation counter = 0.
- Decimation: dec_cnt counts 0..DECIM-1 on each box_valid. A store event occurs when box_valid && dec_cnt==DECIM-1; dec_cnt then returns to 0. With DECIM=1 every valid box is a store event.
- Store, not full: wr_bank[wr_ptr] <= box_data; wr_ptr++; fill++.
- Store, full (fill==DEPTH):
  - WRAP=0: box discarded; wr_drop++ (saturating); wr_ovf=1.
  - WRAP=1: wr_bank[wr_ptr] overwritten; wr_ptr wraps DEPTH-1 -> 0; fill stays DEPTH; wr_ovf=1.
- With WRAP=1, wr_ptr also wraps after slot DEPTH-1 on the filling store.
- frame_end publishes the write bank to the published outputs:
  - bbox_out <= write bank.
  - slot_valid <= (1<<fill)-1, with all ones when fill==DEPTH.
  - box_count <= fill; drop_count <= wr_drop; overflow <= wr_ovf.
  - Write bank reset to CLEAR_VAL; wr_ptr, fill, dec_cnt, wr_drop and wr_ovf cleared.
- Simultaneous frame_end and store event: the box belongs to the ending frame and appears in the published bank, following the full rules above. The new frame starts empty with dec_cnt=0.
- frame_end with an empty write bank: publishes an all-CLEAR_VAL bank with slot_valid=0. out_update still pulses.
- Published outputs change only on frame_end.

## Timing
- All state is registered on posedge clk. rst_n clears asynchronously and its release is synchronous to clk.
- A box sampled at edge N is in the write bank after edge N. It becomes visible on bbox_out only after the edge that samples the next frame_end.
- Publish latency is 1: frame_end sampled at edge N drives new bbox_out/slot_valid/box_count/drop_count/overflow after edge N. out_update is high for exactly the cycle following edge N.
- Back-to-back frame_end pulses each publish, which yields an empty frame for the second pulse.
- No backpressure: the block accepts box_valid every cycle.
- Reset asserted mid-frame discards both banks immediately. The first frame after release starts with dec_cnt=0.

## Structure
- Package bbox_pkg: BOX_W default, CLEAR_VAL default, and box field offsets (x_min/x_max/y_min/y_max, 16 bits each) for downstream consumers.
- Sub-module bbox_decimator (DECIM): box_valid in, store_en out, sync clear on frame_end.
- Top instance holds both banks, pointer, fill/drop counters and publish logic.

## Test plan
- Reset, then no input -> every bbox_out slot = 64'h1, slot_valid=0, box_count=0, out_update=0.
- DECIM=3: 9 valid boxes with data 1..9, then frame_end -> slots 0..2 = 3,6,9; slot_valid=0b0000000111; box_count=3; out_update pulses one cycle.
- DECIM=1, WRAP=0, DEPTH=10: 13 boxes 1..13, then frame_end -> slots 0..9 = 1..10; box_count=10; drop_count=3; overflow=1.
- DECIM=1, WRAP=1: 13 boxes 1..13, then frame_end -> slots 0..2 = 11,12,13 and slots 3..9 = 4..10; box_count=10; drop_count=0; overflow=1.
- A store event in the same cycle as frame_end, data 0xAA, after 2 prior stores -> published slot 2 = 0xAA and box_count=3. A second frame_end with no input -> slot_valid=0 and all slots = 64'h1.
- rst_n pulsed low mid-frame after 5 stores, then frame_end -> box_count=0 and all slots = 64'h1.
